// File: rtl/udma_filter_bincu_pkg.sv
// udma_filter_bincu_pkg
// Shared types and constants for the uDMA filter bincu frame sequencer.
//   seq_state_e       : sequencer FSM states (IDLE -> ARM -> RUN)
//   DEFAULT_LEN_WIDTH : default width of the samples-per-frame field
package udma_filter_bincu_pkg;

   localparam int DEFAULT_LEN_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/udma_filter_bincu_beatcnt.sv
// udma_filter_bincu_beatcnt
// Counts handshaken beats within one frame and flags the first and last beat.
// Ports:
//   clk_i, resetn_i : clock, asynchronous active-low reset
//   clr_i           : synchronous clear (takes priority over en_i)
//   en_i            : count one beat
//   len_i           : frame length in beats (non-zero)
//   first_o         : current count is beat 0
//   last_o          : current count is beat len_i-1
module udma_filter_bincu_beatcnt
   import udma_filter_bincu_pkg::*;
#(
   parameter int LEN_WIDTH = DEFAULT_LEN_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 resetn_i,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   output logic                 first_o,
   output logic                 last_o
);

   localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

   logic [LEN_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + ONE;
      end
   end

   assign first_o = (cnt_q == '0);
   // len_i is never 0 while counting, so len_i-1 cannot wrap in practice
   assign last_o  = (cnt_q == (len_i - ONE));

endmodule

// File: rtl/udma_filter_bincu_seq.sv
// udma_filter_bincu_seq
// Frame sequencer between the filter input stream and the bincu.
// Latches a software job, pulses the bincu counter clear, gates the stream
// handshake during RUN, frames the stream with SOF/EOF and reports
// frame-done / count-reached / illegal-start events.
// Ports:
//   clk_i, resetn_i            : clock, asynchronous active-low reset
//   cfg_*                      : job start/stop pulses and job configuration
//   src_*                      : input stream (data, size code, valid/ready)
//   bcu_data/datasize/valid/sof/eof_o, bcu_ready_i : framed stream to bincu
//   bcu_cmd_start_o            : bincu counter clear pulse (ARM state)
//   bcu_threshold/counter/use_signed/out_enable_o : shadowed job config
//   bcu_act_event_i            : bincu count-reached event
//   busy_o                     : job active (ARM or RUN)
//   done_evt_o, act_irq_o, err_o : registered single-cycle event pulses
//   hit_o                      : sticky count-reached flag for current frame
//   frame_cnt_o                : frames completed since job start
module udma_filter_bincu_seq
   import udma_filter_bincu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TRANS_SIZE = 16,
   parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic                  cfg_start_i,
   input  logic                  cfg_stop_i,
   input  logic                  cfg_continuous_i,
   input  logic [LEN_WIDTH-1:0]  cfg_len_i,
   input  logic [DATA_WIDTH-1:0] cfg_threshold_i,
   input  logic [TRANS_SIZE-1:0] cfg_counter_i,
   input  logic                  cfg_use_signed_i,
   input  logic                  cfg_out_enable_i,
   input  logic [DATA_WIDTH-1:0] src_data_i,
   input  logic [1:0]            src_datasize_i,
   input  logic                  src_valid_i,
   output logic                  src_ready_o,
   output logic [DATA_WIDTH-1:0] bcu_data_o,
   output logic [1:0]            bcu_datasize_o,
   output logic                  bcu_valid_o,
   output logic                  bcu_sof_o,
   output logic                  bcu_eof_o,
   input  logic                  bcu_ready_i,
   output logic                  bcu_cmd_start_o,
   output logic [DATA_WIDTH-1:0] bcu_threshold_o,
   output logic [TRANS_SIZE-1:0] bcu_counter_o,
   output logic                  bcu_use_signed_o,
   output logic                  bcu_out_enable_o,
   input  logic                  bcu_act_event_i,
   output logic                  busy_o,
   output logic                  done_evt_o,
   output logic                  act_irq_o,
   output logic                  err_o,
   output logic                  hit_o,
   output logic [15:0]           frame_cnt_o
);

   seq_state_e state_q;

   logic [LEN_WIDTH-1:0]  len_q;
   logic                  cont_q;
   logic [DATA_WIDTH-1:0] thr_q;
   logic [TRANS_SIZE-1:0] cnt_q;
   logic                  signed_q;
   logic                  out_en_q;

   logic [15:0] frame_cnt_q;
   logic        done_q;
   logic        act_q;
   logic        err_q;
   logic        hit_q;

   logic in_run;
   logic beat;
   logic first_beat;
   logic last_beat;
   logic eof_beat;
   logic idle_start;
   logic start_ok;
   logic frame_done;
   logic load_shadow;

   assign in_run     = (state_q == RUN);
   assign beat       = in_run & src_valid_i & bcu_ready_i;
   assign eof_beat   = beat & last_beat;
   // a stop in the same cycle cancels both a pending start and an EOF completion
   assign idle_start = (state_q == IDLE) & cfg_start_i & ~cfg_stop_i;
   assign start_ok   = idle_start & (cfg_len_i != '0);
   assign frame_done = eof_beat & ~cfg_stop_i;
   // continuous mode re-latches the configuration on every completed frame
   assign load_shadow = start_ok | (frame_done & cont_q);

   udma_filter_bincu_beatcnt #(
      .LEN_WIDTH (LEN_WIDTH)
   ) u_beatcnt (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .clr_i    (state_q == ARM),
      .en_i     (beat),
      .len_i    (len_q),
      .first_o  (first_beat),
      .last_o   (last_beat)
   );

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         len_q    <= '0;
         cont_q   <= 1'b0;
         thr_q    <= '0;
         cnt_q    <= '0;
         signed_q <= 1'b0;
         out_en_q <= 1'b0;
      end else if (load_shadow) begin
         len_q    <= cfg_len_i;
         cont_q   <= cfg_continuous_i;
         thr_q    <= cfg_threshold_i;
         cnt_q    <= cfg_counter_i;
         signed_q <= cfg_use_signed_i;
         out_en_q <= cfg_out_enable_i;
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         done_q      <= 1'b0;
         act_q       <= 1'b0;
         err_q       <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         act_q  <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  frame_cnt_q <= '0;
                  state_q     <= ARM;
               end else if (idle_start) begin
                  err_q <= 1'b1;
               end
            end
            ARM: begin
               hit_q   <= 1'b0;
               state_q <= cfg_stop_i ? IDLE : RUN;
            end
            RUN: begin
               if (bcu_act_event_i) begin
                  act_q <= 1'b1;
                  hit_q <= 1'b1;
               end
               if (cfg_stop_i) begin
                  state_q <= IDLE;
               end else if (eof_beat) begin
                  done_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  state_q     <= cont_q ? ARM : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign src_ready_o    = in_run & bcu_ready_i;
   assign bcu_valid_o    = in_run & src_valid_i;
   assign bcu_sof_o      = bcu_valid_o & first_beat;
   assign bcu_eof_o      = bcu_valid_o & last_beat;
   assign bcu_data_o     = src_data_i;
   assign bcu_datasize_o = src_datasize_i;

   assign bcu_cmd_start_o  = (state_q == ARM);
   assign busy_o           = (state_q != IDLE);
   assign bcu_threshold_o  = thr_q;
   assign bcu_counter_o    = cnt_q;
   assign bcu_use_signed_o = signed_q;
   assign bcu_out_enable_o = out_en_q;

   assign done_evt_o  = done_q;
   assign act_irq_o   = act_q;
   assign err_o       = err_q;
   assign hit_o       = hit_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_udma_filter_bincu_seq.sv
// tb_udma_filter_bincu_seq
// Self-checking bench for the bincu frame sequencer: hand-written sequences
// for the multi-cycle corner cases plus a table of one-shot jobs run with
// random stream stalls against a beat-index reference model.
module tb_udma_filter_bincu_seq;

   logic        clk_i;
   logic        resetn_i;
   logic        cfg_start_i;
   logic        cfg_stop_i;
   logic        cfg_continuous_i;
   logic [15:0] cfg_len_i;
   logic [31:0] cfg_threshold_i;
   logic [15:0] cfg_counter_i;
   logic        cfg_use_signed_i;
   logic        cfg_out_enable_i;
   logic [31:0] src_data_i;
   logic [1:0]  src_datasize_i;
   logic        src_valid_i;
   logic        src_ready_o;
   logic [31:0] bcu_data_o;
   logic [1:0]  bcu_datasize_o;
   logic        bcu_valid_o;
   logic        bcu_sof_o;
   logic        bcu_eof_o;
   logic        bcu_ready_i;
   logic        bcu_cmd_start_o;
   logic [31:0] bcu_threshold_o;
   logic [15:0] bcu_counter_o;
   logic        bcu_use_signed_o;
   logic        bcu_out_enable_o;
   logic        bcu_act_event_i;
   logic        busy_o;
   logic        done_evt_o;
   logic        act_irq_o;
   logic        err_o;
   logic        hit_o;
   logic [15:0] frame_cnt_o;

   int numChecks = 0;
   int numFails  = 0;

   udma_filter_bincu_seq dut (
      .clk_i            (clk_i),
      .resetn_i         (resetn_i),
      .cfg_start_i      (cfg_start_i),
      .cfg_stop_i       (cfg_stop_i),
      .cfg_continuous_i (cfg_continuous_i),
      .cfg_len_i        (cfg_len_i),
      .cfg_threshold_i  (cfg_threshold_i),
      .cfg_counter_i    (cfg_counter_i),
      .cfg_use_signed_i (cfg_use_signed_i),
      .cfg_out_enable_i (cfg_out_enable_i),
      .src_data_i       (src_data_i),
      .src_datasize_i   (src_datasize_i),
      .src_valid_i      (src_valid_i),
      .src_ready_o      (src_ready_o),
      .bcu_data_o       (bcu_data_o),
      .bcu_datasize_o   (bcu_datasize_o),
      .bcu_valid_o      (bcu_valid_o),
      .bcu_sof_o        (bcu_sof_o),
      .bcu_eof_o        (bcu_eof_o),
      .bcu_ready_i      (bcu_ready_i),
      .bcu_cmd_start_o  (bcu_cmd_start_o),
      .bcu_threshold_o  (bcu_threshold_o),
      .bcu_counter_o    (bcu_counter_o),
      .bcu_use_signed_o (bcu_use_signed_o),
      .bcu_out_enable_o (bcu_out_enable_o),
      .bcu_act_event_i  (bcu_act_event_i),
      .busy_o           (busy_o),
      .done_evt_o       (done_evt_o),
      .act_irq_o        (act_irq_o),
      .err_o            (err_o),
      .hit_o            (hit_o),
      .frame_cnt_o      (frame_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [15:0] len;
      logic [31:0] thr;
      logic [15:0] cnt;
      logic        sgn;
      logic        oen;
      int          stopAt;
      logic        expDone;
      logic [15:0] expFrames;
   } jobVec_t;

   jobVec_t vecs[8];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic stop, input logic valid,
                                input logic ready, input logic act);
      cfg_start_i     = start;
      cfg_stop_i      = stop;
      src_valid_i     = valid;
      bcu_ready_i     = ready;
      bcu_act_event_i = act;
   endtask

   task automatic setConfig(input logic [15:0] len, input logic [31:0] thr,
                            input logic [15:0] cnt, input logic sgn, input logic oen,
                            input logic cont);
      cfg_len_i        = len;
      cfg_threshold_i  = thr;
      cfg_counter_i    = cnt;
      cfg_use_signed_i = sgn;
      cfg_out_enable_i = oen;
      cfg_continuous_i = cont;
   endtask

   // One-shot job with random valid/ready stalls and random act events.
   // The model only tracks how many beats the bench has handed over.
   task automatic runJob(input jobVec_t v, input int id);
      int   idx;
      int   cyc;
      bit   ended;
      bit   stopped;
      bit   lastAct;
      bit   expHit;
      logic vld;
      logic rdy;
      logic act;
      logic stp;
      string tag;
      tag = $sformatf("job%0d", id);
      setConfig(v.len, v.thr, v.cnt, v.sgn, v.oen, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      cfg_start_i     = 1'b0;
      cfg_threshold_i = $urandom;
      cfg_counter_i   = 16'($urandom);
      cfg_len_i       = 16'($urandom_range(0, 3));
      #1;
      checkOutput({tag, " arm cmd_start"}, 32'(bcu_cmd_start_o), 32'd1);
      checkOutput({tag, " arm busy"}, 32'(busy_o), 32'd1);
      checkOutput({tag, " arm counter"}, 32'(bcu_counter_o), 32'(v.cnt));
      checkOutput({tag, " arm mode"}, {30'd0, bcu_use_signed_o, bcu_out_enable_o},
                  {30'd0, v.sgn, v.oen});
      checkOutput({tag, " arm frame_cnt"}, 32'(frame_cnt_o), 32'd0);
      tick();
      idx = 0; cyc = 0; ended = 0; stopped = 0; lastAct = 0; expHit = 0;
      while (!ended && cyc < 4000) begin
         vld = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         act = ($urandom_range(0, 7) == 0);
         stp = (idx == v.stopAt);
         src_data_i     = $urandom;
         src_datasize_i = 2'($urandom_range(0, 3));
         applyStimulus(1'b0, stp, vld, rdy, act);
         #1;
         checkOutput({tag, " valid"}, 32'(bcu_valid_o), 32'(vld));
         checkOutput({tag, " ready"}, 32'(src_ready_o), 32'(rdy));
         checkOutput({tag, " sof"}, 32'(bcu_sof_o), 32'(vld && idx == 0));
         checkOutput({tag, " eof"}, 32'(bcu_eof_o), 32'(vld && idx == int'(v.len) - 1));
         checkOutput({tag, " data"}, bcu_data_o, src_data_i);
         checkOutput({tag, " thr"}, bcu_threshold_o, v.thr);
         checkOutput({tag, " act_irq"}, 32'(act_irq_o), 32'(lastAct));
         checkOutput({tag, " hit"}, 32'(hit_o), 32'(expHit));
         lastAct = act;
         if (act) expHit = 1;
         if (stp) begin
            ended   = 1;
            stopped = 1;
         end else if (vld && rdy) begin
            if (idx == int'(v.len) - 1) ended = 1;
            idx++;
         end
         cyc++;
         tick();
      end
      checkOutput({tag, " completed in budget"}, 32'(ended), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput({tag, " end busy"}, 32'(busy_o), 32'd0);
      checkOutput({tag, " end done"}, 32'(done_evt_o), 32'(v.expDone));
      checkOutput({tag, " end model done"}, 32'(done_evt_o), 32'(!stopped));
      checkOutput({tag, " end frame_cnt"}, 32'(frame_cnt_o), 32'(v.expFrames));
      checkOutput({tag, " end act_irq"}, 32'(act_irq_o), 32'(lastAct));
      checkOutput({tag, " end hit"}, 32'(hit_o), 32'(expHit));
      tick();
      #1;
      checkOutput({tag, " done cleared"}, 32'(done_evt_o), 32'd0);
   endtask

   initial begin
      vecs[0] = '{16'd4,   32'd100,        16'd7,   1'b0, 1'b1, -1, 1'b1, 16'd1};
      vecs[1] = '{16'd1,   32'hFFFF_FFFF,  16'd1,   1'b1, 1'b0, -1, 1'b1, 16'd1};
      vecs[2] = '{16'd8,   32'd5,          16'd3,   1'b1, 1'b1,  2, 1'b0, 16'd0};
      vecs[3] = '{16'd5,   32'h8000_0000,  16'hFFFF,1'b0, 1'b0,  0, 1'b0, 16'd0};
      vecs[4] = '{16'd3,   32'd42,         16'd9,   1'b1, 1'b1,  2, 1'b0, 16'd0};
      vecs[5] = '{16'd2,   32'd0,          16'd0,   1'b0, 1'b1, -1, 1'b1, 16'd1};
      vecs[6] = '{16'd300, 32'h1234_5678,  16'd200, 1'b1, 1'b0, -1, 1'b1, 16'd1};
      vecs[7] = '{16'd17,  32'd77,         16'd12,  1'b0, 1'b1, 16, 1'b0, 16'd0};

      resetn_i = 1'b0;
      setConfig(16'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      src_data_i     = 32'hDEAD_BEEF;
      src_datasize_i = 2'd2;
      tick();
      tick();
      #1;
      checkOutput("reset busy", 32'(busy_o), 32'd0);
      checkOutput("reset valid", 32'(bcu_valid_o), 32'd0);
      checkOutput("reset ready", 32'(src_ready_o), 32'd0);
      checkOutput("reset cmd_start", 32'(bcu_cmd_start_o), 32'd0);
      checkOutput("reset events", {28'd0, done_evt_o, act_irq_o, err_o, hit_o}, 32'd0);
      checkOutput("reset frame_cnt", 32'(frame_cnt_o), 32'd0);
      checkOutput("reset thr", bcu_threshold_o, 32'd0);
      checkOutput("idle data passthrough", bcu_data_o, 32'hDEAD_BEEF);
      checkOutput("idle size passthrough", 32'(bcu_datasize_o), 32'd2);
      resetn_i = 1'b1;
      tick();

      // len=4 one-shot, stream always valid and ready
      $display("[TB] len=4 one-shot");
      setConfig(16'd4, 32'd100, 16'd5, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      cfg_start_i = 1'b0;
      #1;
      checkOutput("t1 cmd_start", 32'(bcu_cmd_start_o), 32'd1);
      checkOutput("t1 busy", 32'(busy_o), 32'd1);
      checkOutput("t1 thr", bcu_threshold_o, 32'd100);
      checkOutput("t1 arm valid", 32'(bcu_valid_o), 32'd0);
      checkOutput("t1 arm ready", 32'(src_ready_o), 32'd0);
      for (int b = 0; b < 4; b++) begin
         tick();
         src_data_i = 32'hA000 + 32'(b);
         #1;
         checkOutput("t1 valid", 32'(bcu_valid_o), 32'd1);
         checkOutput("t1 sof", 32'(bcu_sof_o), 32'(b == 0));
         checkOutput("t1 eof", 32'(bcu_eof_o), 32'(b == 3));
         checkOutput("t1 run cmd_start", 32'(bcu_cmd_start_o), 32'd0);
         checkOutput("t1 data", bcu_data_o, 32'hA000 + 32'(b));
      end
      tick();
      #1;
      checkOutput("t1 done", 32'(done_evt_o), 32'd1);
      checkOutput("t1 busy low", 32'(busy_o), 32'd0);
      checkOutput("t1 frame_cnt", 32'(frame_cnt_o), 32'd1);
      checkOutput("t1 idle valid", 32'(bcu_valid_o), 32'd0);
      tick();
      #1;
      checkOutput("t1 done pulse", 32'(done_evt_o), 32'd0);

      // len=1: SOF and EOF on the same beat
      $display("[TB] len=1");
      setConfig(16'd1, 32'd7, 16'd1, 1'b1, 1'b1, 1'b0);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      tick();
      #1;
      checkOutput("t2 sof", 32'(bcu_sof_o), 32'd1);
      checkOutput("t2 eof", 32'(bcu_eof_o), 32'd1);
      tick();
      #1;
      checkOutput("t2 done", 32'(done_evt_o), 32'd1);
      checkOutput("t2 frame_cnt", 32'(frame_cnt_o), 32'd1);
      checkOutput("t2 busy", 32'(busy_o), 32'd0);

      // act event in IDLE is ignored
      bcu_act_event_i = 1'b1;
      tick();
      bcu_act_event_i = 1'b0;
      #1;
      checkOutput("idle act_irq", 32'(act_irq_o), 32'd0);
      checkOutput("idle hit", 32'(hit_o), 32'd0);

      // continuous len=3 with threshold changing per frame
      $display("[TB] continuous len=3");
      setConfig(16'd3, 32'd10, 16'd2, 1'b0, 1'b1, 1'b1);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         #1;
         checkOutput("t3 arm cmd_start", 32'(bcu_cmd_start_o), 32'd1);
         checkOutput("t3 arm ready gap", 32'(src_ready_o), 32'd0);
         checkOutput("t3 arm valid", 32'(bcu_valid_o), 32'd0);
         checkOutput("t3 arm thr", bcu_threshold_o, 32'(10 * f));
         checkOutput("t3 arm frame_cnt", 32'(frame_cnt_o), 32'(f - 1));
         checkOutput("t3 arm done", 32'(done_evt_o), 32'(f > 1));
         cfg_threshold_i = 32'(10 * (f + 1));
         if (f == 2) cfg_continuous_i = 1'b0;
         for (int b = 0; b < 3; b++) begin
            tick();
            #1;
            checkOutput("t3 ready", 32'(src_ready_o), 32'd1);
            checkOutput("t3 sof", 32'(bcu_sof_o), 32'(b == 0));
            checkOutput("t3 eof", 32'(bcu_eof_o), 32'(b == 2));
            checkOutput("t3 thr", bcu_threshold_o, 32'(10 * f));
         end
         tick();
      end
      #1;
      checkOutput("t3 final done", 32'(done_evt_o), 32'd1);
      checkOutput("t3 final frame_cnt", 32'(frame_cnt_o), 32'd3);
      checkOutput("t3 final busy", 32'(busy_o), 32'd0);

      // act event mid-frame
      $display("[TB] act event mid-frame");
      setConfig(16'd4, 32'd1, 16'd1, 1'b0, 1'b0, 1'b0);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      tick();
      tick();
      bcu_act_event_i = 1'b1;
      tick();
      bcu_act_event_i = 1'b0;
      #1;
      checkOutput("t4 act_irq", 32'(act_irq_o), 32'd1);
      checkOutput("t4 hit", 32'(hit_o), 32'd1);
      tick();
      #1;
      checkOutput("t4 act_irq pulse", 32'(act_irq_o), 32'd0);
      checkOutput("t4 eof", 32'(bcu_eof_o), 32'd1);
      tick();
      #1;
      checkOutput("t4 done", 32'(done_evt_o), 32'd1);
      checkOutput("t4 hit held", 32'(hit_o), 32'd1);

      // stop on beat 2 of len=8
      $display("[TB] stop mid-frame");
      setConfig(16'd8, 32'd3, 16'd3, 1'b0, 1'b0, 1'b0);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      tick();
      #1;
      checkOutput("t5 hit cleared", 32'(hit_o), 32'd0);
      checkOutput("t5 frame_cnt cleared", 32'(frame_cnt_o), 32'd0);
      tick();
      tick();
      cfg_stop_i = 1'b1;
      tick();
      cfg_stop_i = 1'b0;
      #1;
      checkOutput("t5 busy", 32'(busy_o), 32'd0);
      checkOutput("t5 done", 32'(done_evt_o), 32'd0);
      checkOutput("t5 frame_cnt", 32'(frame_cnt_o), 32'd0);
      checkOutput("t5 valid", 32'(bcu_valid_o), 32'd0);
      tick();
      #1;
      checkOutput("t5 no late done", 32'(done_evt_o), 32'd0);
      setConfig(16'd2, 32'd9, 16'd3, 1'b0, 1'b0, 1'b0);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      #1;
      checkOutput("t5 restart cmd_start", 32'(bcu_cmd_start_o), 32'd1);
      tick();
      tick();
      tick();
      #1;
      checkOutput("t5 restart done", 32'(done_evt_o), 32'd1);
      checkOutput("t5 restart frame_cnt", 32'(frame_cnt_o), 32'd1);

      // illegal start and start+stop in IDLE
      $display("[TB] illegal starts");
      setConfig(16'd0, 32'd66, 16'd3, 1'b0, 1'b0, 1'b0);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      #1;
      checkOutput("t6 err", 32'(err_o), 32'd1);
      checkOutput("t6 busy", 32'(busy_o), 32'd0);
      checkOutput("t6 thr kept", bcu_threshold_o, 32'd9);
      tick();
      #1;
      checkOutput("t6 err pulse", 32'(err_o), 32'd0);
      cfg_len_i = 16'd4;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      checkOutput("t6 start+stop busy", 32'(busy_o), 32'd0);
      checkOutput("t6 start+stop err", 32'(err_o), 32'd0);

      // start while busy is ignored
      $display("[TB] start while busy");
      setConfig(16'd4, 32'd55, 16'd3, 1'b0, 1'b0, 1'b0);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      tick();
      setConfig(16'd1, 32'd99, 16'd1, 1'b1, 1'b1, 1'b1);
      cfg_start_i = 1'b1;
      for (int b = 1; b < 4; b++) begin
         tick();
         cfg_start_i = 1'b0;
         #1;
         checkOutput("t7 eof", 32'(bcu_eof_o), 32'(b == 3));
         checkOutput("t7 thr", bcu_threshold_o, 32'd55);
      end
      tick();
      #1;
      checkOutput("t7 done", 32'(done_evt_o), 32'd1);
      checkOutput("t7 busy", 32'(busy_o), 32'd0);

      // async reset mid-frame
      $display("[TB] async reset mid-frame");
      setConfig(16'd6, 32'd77, 16'd3, 1'b0, 1'b1, 1'b0);
      cfg_start_i = 1'b1;
      tick();
      cfg_start_i = 1'b0;
      tick();
      tick();
      #2;
      resetn_i = 1'b0;
      #1;
      checkOutput("t8 busy", 32'(busy_o), 32'd0);
      checkOutput("t8 valid", 32'(bcu_valid_o), 32'd0);
      checkOutput("t8 ready", 32'(src_ready_o), 32'd0);
      checkOutput("t8 thr", bcu_threshold_o, 32'd0);
      checkOutput("t8 oen", 32'(bcu_out_enable_o), 32'd0);
      tick();
      resetn_i = 1'b1;
      tick();
      #1;
      checkOutput("t8 no done", 32'(done_evt_o), 32'd0);
      checkOutput("t8 frame_cnt", 32'(frame_cnt_o), 32'd0);

      // table of random-stall jobs
      $display("[TB] random-stall job table");
      for (int i = 0; i < 8; i++) begin
         runJob(vecs[i], i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/udma_filter_bincu_seq.md
# udma_filter_bincu_seq

Frame sequencer for the uDMA filter binarization/counting unit (bincu). Sits between the filter input stream and the bincu. Latches a software job (threshold, count target, frame length), pulses the bincu start, gates the stream handshake, and generates SOF/EOF framing. Reports frame completion and threshold-count events to the uDMA event/IRQ logic, with optional continuous re-arm.

## Interface
- DATA_WIDTH, 32, stream data and threshold width
- TRANS_SIZE, 16, bincu count-target width
- LEN_WIDTH, 16, samples-per-frame width
- clk_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- cfg_start_i / cfg_stop_i  in  1 / 1  single-cycle job start / abort pulses
- cfg_continuous_i  in  1  re-arm automatically after each frame
- cfg_len_i  in  LEN_WIDTH  samples per frame; 0 is illegal
- cfg_threshold_i  in  DATA_WIDTH  job threshold
- cfg_counter_i  in  TRANS_SIZE  job count target
- cfg_use_signed_i / cfg_out_enable_i  in  1 / 1  job mode bits
- src_data_i  in  DATA_WIDTH  input sample
- src_datasize_i  in  2  sample size code
- src_valid_i  in  1  input stream valid
- src_ready_o  out  1  input stream ready
- bcu_data_o  out  DATA_WIDTH  forwarded sample
- bcu_datasize_o  out  2  forwarded size code
- bcu_valid_o / bcu_sof_o / bcu_eof_o  out  1 each  framed stream to bincu
- bcu_ready_i  in  1  bincu ready
- bcu_cmd_start_o  out  1  bincu counter clear pulse
- bcu_threshold_o / bcu_counter_o  out  DATA_WIDTH / TRANS_SIZE  shadowed config
- bcu_use_signed_o / bcu_out_enable_o  out  1 / 1  shadowed mode bits
- bcu_act_event_i  in  1  bincu count-reached event
- busy_o  out  1  job active
- done_evt_o  out  1  frame-complete pulse
- act_irq_o  out  1  count-reached pulse
- err_o  out  1  illegal-start pulse
- hit_o  out  1  sticky: count reached in current frame
- frame_cnt_o  out  16  completed frames since job start

## Operation
- States: IDLE, ARM, RUN.
- IDLE: cfg_start_i with cfg_len_i != 0 -> ARM.
  - Latch all cfg_* into shadow registers; clear frame_cnt_o.
  - cfg_start_i with cfg_len_i == 0: err_o pulse, stay IDLE.
- ARM (1 cycle): bcu_cmd_start_o=1, clear beat counter and hit_o -> RUN.
- RUN gating:
  - bcu_valid_o = src_valid_i; src_ready_o = bcu_ready_i.
  - Beat = bcu_valid_o & bcu_ready_i; beat counter increments per beat.
  - bcu_sof_o = valid & (cnt==0); bcu_eof_o = valid & (cnt==len-1); len==1 gives SOF and EOF together.
- Outside RUN: src_ready_o=0, bcu_valid_o=0.
- EOF beat:
  - frame_cnt_o++ (wraps at 16'hFFFF).
  - Continuous: -> ARM, re-latching cfg_* (threshold/length updates apply per frame).
  - Otherwise: -> IDLE.
- bcu_act_event_i in RUN: act_irq_o pulse and hit_o=1; ignored in IDLE/ARM.
- cfg_stop_i in ARM/RUN: -> IDLE, no done_evt_o, frame_cnt_o held.
  - A beat handshaken in the same cycle still transfers but is not counted as frame completion.
- Priorities: stop > EOF completion. cfg_start_i while busy is ignored. Start and stop in the same IDLE cycle: start ignored.
- Data/datasize pass through combinationally in all states.

## Timing
- Reset values:
  - State IDLE; all shadows 0; frame_cnt_o 0.
  - busy_o, done_evt_o, act_irq_o, err_o, hit_o, bcu_cmd_start_o all 0.
  - src_ready_o and bcu_valid_o 0.
- Start sampled at cycle t:
  - bcu_cmd_start_o and busy_o high at t+1.
  - RUN and first possible beat at t+2.
- done_evt_o: registered, high the cycle after the EOF beat.
- act_irq_o: registered, high the cycle after bcu_act_event_i.
- err_o: registered, high the cycle after an illegal start.
- Continuous mode: exactly one dead cycle (ARM) between EOF beat and next SOF beat.
- busy_o is 1 in ARM/RUN; it falls the cycle after the final EOF or stop.
- Async reset mid-frame: immediate return to IDLE, all outputs at reset values, no events emitted.

## Structure
- Package udma_filter_bincu_pkg: state enum typedef (IDLE/ARM/RUN), default LEN_WIDTH constant.
- Sub-module udma_filter_bincu_beatcnt: LEN_WIDTH beat counter with clear, enable, first/last flags; instantiated once.
- FSM, shadow registers and event registers live in the top.

## Test plan
- len=4, one-shot, threshold 100, src always valid, ready always high:
  - cmd_start at t+1; beats t+2..t+5; SOF on beat 0, EOF on beat 3.
  - done_evt_o at t+6; busy_o low at t+6; frame_cnt_o=1.
- len=1: single beat carries SOF and EOF together; done_evt_o next cycle.
- Continuous, len=3, threshold changed between frames:
  - One-cycle ready gap and cmd_start per frame; frame 2 uses the new threshold.
  - frame_cnt_o = 1, 2, 3.
- bcu_act_event_i pulsed mid-frame: act_irq_o one cycle later; hit_o=1 until next ARM.
- cfg_stop_i on beat 2 of len=8: IDLE next cycle, no done_evt_o, frame_cnt_o unchanged, later start accepted.
- cfg_len_i=0 start: err_o pulse, busy_o stays 0. Start while busy: ignored, no shadow change.
